// File: rtl/mem_access_unit.sv
// Memory access unit: local word RAM with an independent fetch port, plus an
// MMIO bridge with a bounded wait and error response.
module mem_access_unit #(
   parameter int unsigned DEPTH_LOG2 = 14,
   parameter logic [15:0] MMIO_HI    = 16'hFFFF,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic        req_unsigned_i,
   input  logic [1:0]  req_size_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_rdata_o,
   output logic        mmio_req_o,
   output logic        mmio_we_o,
   output logic [31:0] mmio_addr_o,
   output logic [31:0] mmio_wdata_o,
   output logic [3:0]  mmio_be_o,
   input  logic [31:0] mmio_rdata_i,
   input  logic        mmio_ack_i
);

   localparam int unsigned Words = 2 ** DEPTH_LOG2;
   localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StRamRsp, StMmioWait, StRsp} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic [1:0]            off_q, size_q;
   logic                  uns_q, we_q;
   logic [31:0]           mmio_addr_q, mmio_wdata_q, mmio_rdata_q;
   logic [3:0]            mmio_be_q;
   logic [31:0]           ram_rdata_q, if_data_q;
   logic [31:0]           mem_q [Words];

   logic                  accept, misaligned, is_mmio, ram_wr, ram_rd, mmio_cap;
   logic [3:0]            lane_be;
   logic [31:0]           lane_wdata;
   logic [DEPTH_LOG2-1:0] req_idx, if_idx;
   logic                  unused_if_addr;

   // Select the addressed lane of a word and sign/zero-extend it to 32 bits.
   function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         2'b00:   extend = {{24{~uns & sh[7]}}, sh[7:0]};
         2'b01:   extend = {{16{~uns & sh[15]}}, sh[15:0]};
         default: extend = sh;
      endcase
   endfunction

   assign req_idx        = req_addr_i[DEPTH_LOG2+1:2];
   assign if_idx         = if_addr_i[DEPTH_LOG2+1:2];
   assign unused_if_addr = ^{if_addr_i[31:DEPTH_LOG2+2], if_addr_i[1:0]};

   assign accept     = req_valid_i && (state_q == StIdle);
   assign is_mmio    = (req_addr_i[31:16] == MMIO_HI);
   assign misaligned = (req_size_i == 2'b11) ||
                       (req_size_i == 2'b01 && req_addr_i[0]) ||
                       (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
   // Writes are blocked during reset so a held request cannot corrupt RAM.
   assign ram_wr     = accept && !reset_i && req_we_i && !misaligned && !is_mmio;
   assign ram_rd     = accept && !req_we_i && !misaligned && !is_mmio;

   // Byte enables and lane-positioned store data from size and address offset.
   always_comb begin
      lane_be    = 4'b0000;
      lane_wdata = 32'h0;
      case (req_size_i)
         2'b00: begin
            lane_be    = 4'b0001 << req_addr_i[1:0];
            lane_wdata = {24'h0, req_wdata_i[7:0]} << {req_addr_i[1:0], 3'b000};
         end
         2'b01: begin
            lane_be    = 4'b0011 << req_addr_i[1:0];
            lane_wdata = {16'h0, req_wdata_i[15:0]} << {req_addr_i[1:0], 3'b000};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = req_wdata_i;
         end
      endcase
   end

   // Next-state logic; an ack in the timeout cycle takes priority over the error.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      mmio_cap = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d = '0;
               err_d = misaligned;
               if (misaligned)   state_d = StRsp;
               else if (is_mmio) state_d = StMmioWait;
               else              state_d = StRamRsp;
            end
         end
         StRamRsp: state_d = StIdle;
         StMmioWait: begin
            if (mmio_ack_i) begin
               mmio_cap = 1'b1;
               err_d    = 1'b0;
               state_d  = StRsp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = StRsp;
               end
            end
         end
         StRsp:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Control state and request capture.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         off_q        <= 2'b00;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         we_q         <= 1'b0;
         mmio_addr_q  <= 32'h0;
         mmio_wdata_q <= 32'h0;
         mmio_be_q    <= 4'b0000;
         mmio_rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (accept) begin
            off_q        <= req_addr_i[1:0];
            size_q       <= req_size_i;
            uns_q        <= req_unsigned_i;
            we_q         <= req_we_i;
            mmio_addr_q  <= req_addr_i;
            mmio_wdata_q <= lane_wdata;
            mmio_be_q    <= lane_be;
         end
         if (mmio_cap) mmio_rdata_q <= mmio_rdata_i;
      end
   end

   // RAM data port: byte-lane writes and load read on the acceptance edge.
   always_ff @(posedge clk_i) begin
      if (ram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_be[b]) mem_q[req_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
         end
      end
      if (ram_rd) ram_rdata_q <= mem_q[req_idx];
   end

   // Fetch port: read-first against a same-edge store since both use old mem_q.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) if_data_q <= 32'h0;
      else         if_data_q <= mem_q[if_idx];
   end

   assign if_data_o = if_data_q;

   // Outputs decoded from the current state; MMIO lines are zero unless waiting.
   always_comb begin
      req_ready_o  = (state_q == StIdle);
      rsp_valid_o  = 1'b0;
      rsp_err_o    = 1'b0;
      rsp_rdata_o  = 32'h0;
      mmio_req_o   = 1'b0;
      mmio_we_o    = 1'b0;
      mmio_addr_o  = 32'h0;
      mmio_wdata_o = 32'h0;
      mmio_be_o    = 4'b0000;
      unique case (state_q)
         StRamRsp: begin
            rsp_valid_o = 1'b1;
            if (!we_q) rsp_rdata_o = extend(ram_rdata_q, off_q, size_q, uns_q);
         end
         StMmioWait: begin
            mmio_req_o   = 1'b1;
            mmio_we_o    = we_q;
            mmio_addr_o  = mmio_addr_q;
            mmio_wdata_o = mmio_wdata_q;
            mmio_be_o    = mmio_be_q;
         end
         StRsp: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = err_q;
            if (!err_q && !we_q) rsp_rdata_o = extend(mmio_rdata_q, off_q, size_q, uns_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench with a byte-level memory model and a per-cycle compare process.
module tb_mem_access_unit;

   localparam int unsigned DepthLog2 = 10;
   localparam int unsigned Timeout   = 15;
   localparam int unsigned RamBytes  = 4 << DepthLog2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] if_addr = 32'h100;
   logic [31:0] if_data_o;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready_o, rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        mmio_req_o, mmio_we_o;
   logic [31:0] mmio_addr_o, mmio_wdata_o;
   logic [3:0]  mmio_be_o;
   logic [31:0] mmio_rdata = 32'h0;
   logic        mmio_ack = 1'b0;

   mem_access_unit #(
      .DEPTH_LOG2(DepthLog2),
      .MMIO_HI   (16'hFFFF),
      .TIMEOUT   (Timeout)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .if_addr_i     (if_addr),
      .if_data_o     (if_data_o),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we),
      .req_unsigned_i(req_unsigned),
      .req_size_i    (req_size),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .mmio_req_o    (mmio_req_o),
      .mmio_we_o     (mmio_we_o),
      .mmio_addr_o   (mmio_addr_o),
      .mmio_wdata_o  (mmio_wdata_o),
      .mmio_be_o     (mmio_be_o),
      .mmio_rdata_i  (mmio_rdata),
      .mmio_ack_i    (mmio_ack)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Expected outputs for the current cycle, set by the stimulus tasks.
   logic        chk_en = 1'b0, exp_reset = 1'b1;
   logic        exp_ready = 1'b1, exp_rsp_valid = 1'b0, exp_rsp_err = 1'b0;
   logic [31:0] exp_rsp_rdata = 32'h0;
   logic        exp_mmio_req = 1'b0, exp_mmio_we = 1'b0;
   logic [3:0]  exp_mmio_be = 4'h0;
   logic [31:0] exp_mmio_addr = 32'h0, exp_mmio_wdata = 32'h0;
   logic        exp_if_known = 1'b0;
   logic [31:0] exp_if = 32'h0;

   // Byte-addressed RAM model plus one pending store applied at the acceptance edge.
   logic [7:0]  mdl [int unsigned];
   logic        st_pend = 1'b0;
   logic [31:0] st_addr = 32'h0, st_data = 32'h0;
   logic [1:0]  st_size = 2'b00;

   // Values sampled from the DUT for the literal checks.
   logic [31:0] got_rdata, got_if, got_wdata;
   logic        got_err, got_valid;
   logic [3:0]  got_be;
   int          req_cnt;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned akey(input logic [31:0] a);
      return a % RamBytes;
   endfunction

   function automatic bit is_mis(input logic [1:0] s, input logic [31:0] a);
      if (s == 2'd3) return 1'b1;
      return (a % (32'd1 << s)) != 0;
   endfunction

   function automatic bit known_word(input logic [31:0] a);
      int unsigned base = akey(a) - (akey(a) % 4);
      for (int i = 0; i < 4; i++) if (!mdl.exists(base + i)) return 1'b0;
      return 1'b1;
   endfunction

   // Keep n bytes of v and sign- or zero-extend them to 32 bits.
   function automatic logic [31:0] ext_val(input longint unsigned v, input int n, input bit uns);
      longint unsigned lim = 64'd1 << (8 * n);
      v = v % lim;
      if (!uns && n < 4 && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
      return 32'(v);
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s,
                                            input bit uns);
      longint unsigned v = 0;
      int n = 1 << s;
      for (int i = 0; i < n; i++) v = v | (longint'(mdl[akey(a) + i]) << (8 * i));
      return ext_val(v, n, uns);
   endfunction

   // Fetch expectation is taken before the store lands (read-first).
   always @(posedge clk) begin
      if (reset) begin
         exp_if_known = 1'b0;
      end else begin
         exp_if_known = known_word(if_addr);
         if (exp_if_known) exp_if = mdl_load(if_addr & ~32'h3, 2'd2, 1'b1);
         if (st_pend) begin
            for (int i = 0; i < (1 << st_size); i++) mdl[akey(st_addr) + i] = st_data[8*i +: 8];
            st_pend = 1'b0;
         end
      end
   end

   // Compare process, sampling half a cycle after the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("req_ready", req_ready_o, exp_ready);
         check_eq("rsp_valid", rsp_valid_o, exp_rsp_valid);
         check_eq("mmio_req", mmio_req_o, exp_mmio_req);
         if (exp_reset) begin
            check_eq("rst_rsp_err", rsp_err_o, 0);
            check_eq("rst_rsp_rdata", rsp_rdata_o, 0);
            check_eq("rst_mmio_we", mmio_we_o, 0);
            check_eq("rst_mmio_be", mmio_be_o, 0);
            check_eq("rst_mmio_addr", mmio_addr_o, 0);
            check_eq("rst_mmio_wdata", mmio_wdata_o, 0);
            check_eq("rst_if_data", if_data_o, 0);
         end else begin
            if (exp_rsp_valid) begin
               check_eq("rsp_err", rsp_err_o, exp_rsp_err);
               check_eq("rsp_rdata", rsp_rdata_o, exp_rsp_rdata);
            end
            if (exp_mmio_req) begin
               check_eq("mmio_we", mmio_we_o, exp_mmio_we);
               check_eq("mmio_be", mmio_be_o, exp_mmio_be);
               check_eq("mmio_addr", mmio_addr_o, exp_mmio_addr);
               check_eq("mmio_wdata", mmio_wdata_o, exp_mmio_wdata);
            end
            if (exp_if_known) check_eq("if_data", if_data_o, exp_if);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_exp();
      exp_ready     = 1'b1;
      exp_rsp_valid = 1'b0;
      exp_mmio_req  = 1'b0;
   endtask

   task automatic idle(input int n, input logic ack);
      repeat (n) begin
         cyc();
         req_valid = 1'b0;
         mmio_ack  = ack;
         set_idle_exp();
      end
   endtask

   task automatic drive_req(input bit we, input bit uns, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] wd);
      req_valid    = 1'b1;
      req_we       = we;
      req_unsigned = uns;
      req_size     = s;
      req_addr     = a;
      req_wdata    = wd;
      mmio_ack     = 1'b0;
      set_idle_exp();
   endtask

   // RAM access or any misaligned request: response one cycle after acceptance.
   task automatic quick_op(input bit we, input bit uns, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] wd);
      bit          e_err;
      logic [31:0] e_rdata;
      cyc();
      drive_req(we, uns, s, a, wd);
      e_err   = is_mis(s, a);
      e_rdata = (e_err || we) ? 32'h0 : mdl_load(a, s, uns);
      if (we && !e_err) begin
         st_pend = 1'b1;
         st_addr = a;
         st_size = s;
         st_data = wd;
      end
      cyc();
      req_valid     = 1'b0;
      exp_ready     = 1'b0;
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = e_err;
      exp_rsp_rdata = e_rdata;
      exp_mmio_req  = 1'b0;
      #3;
      got_rdata = rsp_rdata_o;
      got_err   = rsp_err_o;
      got_valid = rsp_valid_o;
      got_if    = if_data_o;
   endtask

   // MMIO access with ack in wait cycle ack_at (0 = never).
   task automatic mmio_op(input bit we, input bit uns, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] ack_data);
      int n = 1 << s;
      bit acked = 1'b0;
      cyc();
      drive_req(we, uns, s, a, wd);
      req_cnt = 0;
      for (int k = 1; k <= int'(Timeout) && !acked; k++) begin
         cyc();
         req_valid      = 1'b0;
         mmio_ack       = (k == ack_at);
         mmio_rdata     = (k == ack_at) ? ack_data : 32'hBAD0_BAD0;
         exp_ready      = 1'b0;
         exp_rsp_valid  = 1'b0;
         exp_mmio_req   = 1'b1;
         exp_mmio_we    = we;
         exp_mmio_addr  = a;
         exp_mmio_be    = 4'(((1 << n) - 1) << (a % 4));
         exp_mmio_wdata = 32'((longint'(wd) % (64'd1 << (8 * n))) << (8 * (a % 4)));
         #3;
         if (mmio_req_o) req_cnt++;
         if (k == 1) begin
            got_be    = mmio_be_o;
            got_wdata = mmio_wdata_o;
         end
         acked = (k == ack_at);
      end
      cyc();
      mmio_ack      = 1'b0;
      exp_mmio_req  = 1'b0;
      exp_ready     = 1'b0;
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = !acked;
      exp_rsp_rdata = (!acked || we) ? 32'h0 : ext_val(longint'(ack_data >> (8 * (a % 4))), n, uns);
      #3;
      got_rdata = rsp_rdata_o;
      got_err   = rsp_err_o;
      got_valid = rsp_valid_o;
   endtask

   // Reset pulse in the middle of an MMIO wait.
   task automatic reset_mid_mmio();
      cyc();
      drive_req(1'b0, 1'b0, 2'b10, 32'hFFFF_0020, 32'h0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         req_valid      = 1'b0;
         exp_ready      = 1'b0;
         exp_mmio_req   = 1'b1;
         exp_mmio_we    = 1'b0;
         exp_mmio_addr  = 32'hFFFF_0020;
         exp_mmio_be    = 4'hF;
         exp_mmio_wdata = 32'h0;
      end
      #2;
      reset        = 1'b1;
      exp_reset    = 1'b1;
      exp_ready    = 1'b1;
      exp_mmio_req = 1'b0;
      #1;
      check_eq("mmio_req_async_reset", mmio_req_o, 0);
      cyc();
      cyc();
      cyc();
      reset     = 1'b0;
      exp_reset = 1'b0;
      set_idle_exp();
      idle(3, 1'b0);
      check_eq("ready_after_reset", req_ready_o, 1);
   endtask

   initial begin
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      exp_reset = 1'b0;
      set_idle_exp();
      idle(2, 1'b1);

      quick_op(1'b1, 1'b0, 2'b10, 32'h100, 32'hDEADBEEF);
      check_eq("store_word_err", got_err, 0);
      quick_op(1'b0, 1'b0, 2'b00, 32'h101, 32'h0);
      check_eq("lb_signed", got_rdata, 32'hFFFFFFBE);
      check_eq("lb_signed_valid", got_valid, 1);
      quick_op(1'b0, 1'b1, 2'b00, 32'h101, 32'h0);
      check_eq("lb_unsigned", got_rdata, 32'h000000BE);

      quick_op(1'b1, 1'b0, 2'b01, 32'h102, 32'h0000_1234);
      check_eq("fetch_read_first", got_if, 32'hDEADBEEF);
      idle(1, 1'b0);
      #3;
      check_eq("fetch_after_store", if_data_o, 32'h1234BEEF);
      quick_op(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
      check_eq("lw_merged", got_rdata, 32'h1234BEEF);

      quick_op(1'b0, 1'b0, 2'b10, 32'h102, 32'h0);
      check_eq("lw_misaligned_err", got_err, 1);
      check_eq("lw_misaligned_rdata", got_rdata, 0);
      quick_op(1'b1, 1'b0, 2'b10, 32'h101, 32'hFFFF_FFFF);
      quick_op(1'b0, 1'b1, 2'b11, 32'h100, 32'h0);
      check_eq("size11_err", got_err, 1);
      quick_op(1'b0, 1'b0, 2'b10, 32'h1100, 32'h0);
      check_eq("alias_unchanged", got_rdata, 32'h1234BEEF);

      quick_op(1'b1, 1'b0, 2'b10, 32'h200, 32'h0000_8001);
      quick_op(1'b0, 1'b0, 2'b01, 32'h200, 32'h0);
      check_eq("lh_signed", got_rdata, 32'hFFFF8001);
      quick_op(1'b0, 1'b1, 2'b01, 32'h202, 32'h0);
      quick_op(1'b0, 1'b0, 2'b01, 32'h201, 32'h0);
      quick_op(1'b0, 1'b0, 2'b10, 32'hFFFF_0001, 32'h0);
      idle(2, 1'b1);

      mmio_op(1'b1, 1'b0, 2'b00, 32'hFFFF_0003, 32'h0000_00A5, 3, 32'h0);
      check_eq("mmio_sb_be", got_be, 4'b1000);
      check_eq("mmio_sb_wdata", got_wdata, 32'hA500_0000);
      check_eq("mmio_sb_req_cycles", req_cnt, 3);
      check_eq("mmio_sb_err", got_err, 0);
      mmio_op(1'b0, 1'b0, 2'b10, 32'hFFFF_0010, 32'h0, 1, 32'h89AB_CDEF);
      check_eq("mmio_lw", got_rdata, 32'h89AB_CDEF);
      mmio_op(1'b0, 1'b0, 2'b00, 32'hFFFF_0012, 32'h0, 2, 32'h00F0_0000);
      check_eq("mmio_lb_signed", got_rdata, 32'hFFFF_FFF0);
      mmio_op(1'b0, 1'b0, 2'b10, 32'hFFFF_0004, 32'h0, 0, 32'h0);
      check_eq("timeout_req_cycles", req_cnt, 15);
      check_eq("timeout_err", got_err, 1);
      check_eq("timeout_rdata", got_rdata, 0);
      mmio_op(1'b0, 1'b1, 2'b01, 32'hFFFF_0002, 32'h0, 15, 32'hCAFE_0000);
      check_eq("ack_at_timeout_err", got_err, 0);
      check_eq("ack_at_timeout_rdata", got_rdata, 32'h0000_CAFE);

      reset_mid_mmio();
      quick_op(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
      check_eq("ram_kept_over_reset", got_rdata, 32'h1234BEEF);
      idle(2, 1'b0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 14, giving the RAM word-address width (2^DEPTH_LOG2 32-bit words).
REQ-002 SHALL have parameter MMIO_HI, default 16'hFFFF, the value of addr[31:16] that selects the MMIO region.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of MMIO wait cycles before an error response.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_addr  in  32  instruction fetch byte address.
REQ-007 if_data  out  32  fetched word, registered.
REQ-008 req_valid  in  1  data request valid.
REQ-009 req_ready  out  1  unit can accept a request.
REQ-010 req_we, req_unsigned  in  1 each  store select; zero-extend on load.
REQ-011 req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-012 req_addr, req_wdata  in  32 each  byte address; store data (right-aligned).
REQ-013 rsp_valid, rsp_err  out  1 each  response strobe; error flag.
REQ-014 rsp_rdata  out  32  load result, aligned and extended.
REQ-015 mmio_req, mmio_we  out  1 each  MMIO request; MMIO write select.
REQ-016 mmio_addr, mmio_wdata  out  32 each  MMIO address; lane-positioned write data.
REQ-017 mmio_be  out  4  MMIO byte enables.
REQ-018 mmio_rdata  in  32  MMIO read data.
REQ-019 mmio_ack  in  1  MMIO completion strobe.

Function
REQ-020 SHALL implement states IDLE, RAM_RSP, MMIO_WAIT and RSP; req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when req_valid&&req_ready.
REQ-021 Misalignment check: the request SHALL be misaligned when size=01 with addr[0]=1, when size=10 with addr[1:0]!=0, or when size=11; a misaligned request SHALL touch neither RAM nor MMIO, and the unit SHALL go to RSP with rsp_err=1 and rsp_rdata=0.
REQ-022 RAM region is every address with addr[31:16]!=MMIO_HI; the word index SHALL be addr[DEPTH_LOG2+1:2], and higher address bits SHALL alias.
REQ-023 RAM store SHALL write only the lanes addressed by size and addr[1:0] (little-endian) on the acceptance edge.
REQ-024 RAM load SHALL read on the acceptance edge, and the unit SHALL then go to RAM_RSP.
REQ-025 In RAM_RSP, the unit SHALL assert rsp_valid for exactly 1 cycle (1 cycle after acceptance) and SHALL return to IDLE.
REQ-026 Load data SHALL select the lane from addr[1:0], sign-extend it unless req_unsigned=1, and return rsp_rdata=0 for stores.
REQ-027 MMIO access: from the cycle after acceptance, the unit SHALL hold mmio_req=1 with mmio_addr, mmio_we, mmio_be and mmio_wdata (shifted to lane) stable until mmio_ack is sampled high.
REQ-028 On mmio_ack, the unit SHALL drop mmio_req, capture mmio_rdata, and assert rsp_valid on the next cycle (state RSP) with extended data and rsp_err=0.
REQ-029 A wait counter SHALL increment on each MMIO_WAIT cycle without ack.
REQ-030 When the counter reaches TIMEOUT, the unit SHALL drop mmio_req and give an RSP with rsp_err=1 and rsp_rdata=0.
REQ-031 An ack arriving in the same cycle as the timeout SHALL win (no error).
REQ-032 RSP SHALL last exactly 1 cycle, then the unit SHALL return to IDLE.
REQ-033 The fetch port SHALL be independent: if_data SHALL be RAM[if_addr[DEPTH_LOG2+1:2]], 1 cycle latency, every cycle, in all states.
REQ-034 A fetch and a store to the same word on the same edge SHALL return the old data (read-first).
REQ-035 mmio_ack outside MMIO_WAIT SHALL be ignored.

Reset
REQ-036 While reset is high, the unit SHALL hold state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mmio_req=0, mmio_we=0, mmio_be=0, mmio_addr=0, mmio_wdata=0, wait counter=0 and if_data=0.
REQ-037 Reset asserted mid-transaction SHALL abort it immediately (mmio_req low asynchronously) with no response issued.
REQ-038 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-039 Store word 0xDEADBEEF @0x100, then load byte @0x101 signed -> rsp_rdata 0xFFFFFFBE; same load unsigned -> 0x000000BE; rsp_valid 1 cycle after acceptance.
REQ-040 Store half 0x1234 @0x102 over 0xDEADBEEF, then load word @0x100 -> 0x1234BEEF; if_addr=0x100 one cycle after that store -> if_data 0x1234BEEF.
REQ-041 Load word @0x102 -> rsp_err=1, rsp_rdata=0, RAM unchanged, mmio_req never high.
REQ-042 Store byte 0xA5 @0xFFFF0003 with ack after 3 cycles -> mmio_be=1000, mmio_wdata=0xA5000000 held stable 3 cycles, rsp_valid the cycle after ack, rsp_err=0.
REQ-043 MMIO load with no ack -> mmio_req drops after 15 wait cycles, rsp_err=1; a second run with ack on the 15th cycle -> rsp_err=0.
REQ-044 Reset pulse during MMIO_WAIT -> mmio_req=0 immediately, no rsp_valid, req_ready=1 after reset release.
